// File: rtl/mdu_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface mdu_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mdu.sv
// Iterative RV M-extension mul/div: one result bit per cycle, XLEN+2 latency, result held until taken.
// Optional macro MDU_EARLY_OUT_EN sends div-by-zero, signed overflow and zero multiplies straight to DONE.
module mdu #(
  parameter int XLEN = 32
) (
  input  logic clock,
  input  logic reset_n,
  input  logic flush,
  mdu_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_op;
  logic [XLEN-1:0]     r_opnd;
  logic [2*XLEN-1:0]   r_acc;
  logic                r_neg;
  logic                r_spec;
  logic [XLEN-1:0]     r_spec_res;
  logic [CW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_result;

  logic                w_accept, w_is_div;
  logic                w_sgn_a, w_sgn_b, w_neg;
  logic [XLEN-1:0]     w_mag_a, w_mag_b;
  logic                w_div0, w_ovf, w_mul0, w_spec;
  logic [XLEN-1:0]     w_spec_res;
  logic [XLEN:0]       w_sum, w_rem_sh, w_diff;
  logic [2*XLEN-1:0]   w_mul_nxt, w_div_nxt, w_prod_fix;
  logic [XLEN-1:0]     w_qr, w_qr_fix, w_fix_res;

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;

  assign w_accept = bus.in_valid & (r_state == IDLE) & ~flush;
  assign w_is_div = bus.op[2];

  // MULH, MULHSU, DIV and REM read rs1 as signed; only MULH, DIV and REM read rs2 as signed.
  assign w_sgn_a = bus.operand_a[XLEN-1] &
                   ((bus.op == 3'b001) | (bus.op == 3'b010) | (bus.op == 3'b100) | (bus.op == 3'b110));
  assign w_sgn_b = bus.operand_b[XLEN-1] &
                   ((bus.op == 3'b001) | (bus.op == 3'b100) | (bus.op == 3'b110));
  assign w_mag_a = w_sgn_a ? (~bus.operand_a + 1'b1) : bus.operand_a;
  assign w_mag_b = w_sgn_b ? (~bus.operand_b + 1'b1) : bus.operand_b;
  assign w_neg   = (w_is_div & bus.op[1]) ? w_sgn_a : (w_sgn_a ^ w_sgn_b);

  assign w_div0 = w_is_div & (bus.operand_b == '0);
  assign w_ovf  = w_is_div & ~bus.op[0] & (bus.operand_a == MIN_VAL) & (bus.operand_b == '1);
  assign w_mul0 = ~w_is_div & ((bus.operand_a == '0) | (bus.operand_b == '0));
  assign w_spec = w_div0 | w_ovf | w_mul0;

  always_comb begin
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = bus.op[1] ? bus.operand_a : '1;
    else if (w_ovf)
      w_spec_res = bus.op[1] ? '0 : MIN_VAL;
  end

  // Multiply: multiplier sits in the low half and is shifted out while partial sums enter the top.
  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
  assign w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};

  // Divide: remainder in the high half, dividend shifts up out of the low half as quotient bits enter.
  assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff    = w_rem_sh - {1'b0, r_opnd};
  assign w_div_nxt = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                  : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};

  assign w_prod_fix = r_neg ? (~r_acc + 1'b1) : r_acc;
  assign w_qr       = r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
  assign w_qr_fix   = r_neg ? (~w_qr + 1'b1) : w_qr;

  always_comb begin
    w_fix_res = w_qr_fix;
    if (r_spec)
      w_fix_res = r_spec_res;
    else if (!r_op[2])
      w_fix_res = (r_op == 3'b000) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
`ifdef MDU_EARLY_OUT_EN
          w_state_nxt = w_spec ? DONE : CALC;
`else
          w_state_nxt = CALC;
`endif
        end
      end
      CALC:    if (r_cnt == '0) w_state_nxt = FIX;
      FIX:     w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush)
      w_state_nxt = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op       <= '0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_neg      <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_res <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op       <= bus.op;
            r_opnd     <= w_is_div ? w_mag_b : w_mag_a;
            r_acc      <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            r_neg      <= w_neg;
            r_spec     <= w_spec;
            r_spec_res <= w_spec_res;
            r_cnt      <= CW'(XLEN - 1);
`ifdef MDU_EARLY_OUT_EN
            if (w_spec)
              r_result <= w_spec_res;
`endif
          end
        end
        CALC: begin
          r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
          if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
        end
        FIX:     r_result <= w_fix_res;
        default: ;
      endcase
    end
  end
endmodule
